// File: rtl/irq_controller_if.sv
// Bus bundle between the core/register bus and the interrupt controller.
// Carries the timer flags, the register port and the interrupt handshake.
interface irq_controller_if #(
    parameter int NUM_IRQ_SOURCES = 4,
    parameter int DATA_WIDTH      = 8
);
    localparam int ID_W = (NUM_IRQ_SOURCES > 1) ? $clog2(NUM_IRQ_SOURCES) : 1;

    logic [NUM_IRQ_SOURCES-1:0] irq_src;
    logic [1:0]                 addr;
    logic                       wr_en;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic                       irq_ack;
    logic                       irq_eoi;
    logic                       irq_req;
    logic [ID_W-1:0]            irq_id;

    // Handshake: irq_req acts as valid and stays high with irq_id stable until a
    // one-cycle irq_ack (ready) is seen or the request is withdrawn; irq_eoi then
    // closes the service period. Pulses outside their phase are ignored.
    modport master (
        output irq_src, addr, wr_en, wr_data, irq_ack, irq_eoi,
        input  rd_data, irq_req, irq_id
    );

    modport slave (
        input  irq_src, addr, wr_en, wr_data, irq_ack, irq_eoi,
        output rd_data, irq_req, irq_id
    );
endinterface

// File: rtl/irq_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller with a
// memory-mapped ENABLE/PENDING/CAUSE/CTRL register file and req/ack/eoi handshake.
module irq_controller #(
    parameter int NUM_IRQ_SOURCES = 4,
    parameter int DATA_WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    irq_controller_if.slave  bus,
    output logic [1:0]       dbg_state_o
);
    localparam int N    = NUM_IRQ_SOURCES;
    localparam int DW   = DATA_WIDTH;
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e          state_q;
    logic            req_q;
    logic [ID_W-1:0] id_q;
    logic [N-1:0]    src_q, enable_q, pending_q;
    logic [N-1:0]    enable_d, pending_d;
    logic            gie_q, gie_d;
    logic [DW-1:0]   rd_q, rd_d;

    logic [N-1:0]    rise, active, w1c, ack_clr;
    logic [ID_W-1:0] sel_id;
    logic [DW-1:0]   cause;
    logic            ack_take, withdraw;
    logic            unused_wr_bits;

    assign unused_wr_bits = &{1'b0, bus.wr_data};

    always_comb begin
        rise   = bus.irq_src & ~src_q;
        active = pending_q & enable_q;

        sel_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (active[i]) sel_id = ID_W'(i);
        end

        enable_d = enable_q;
        gie_d    = gie_q;
        w1c      = '0;
        if (bus.wr_en) begin
            case (bus.addr)
                2'd0:    enable_d = bus.wr_data[N-1:0];
                2'd1:    w1c      = bus.wr_data[N-1:0];
                2'd3:    gie_d    = bus.wr_data[0];
                default: ;
            endcase
        end

        ack_take = (state_q == ST_REQ) && bus.irq_ack;
        ack_clr  = '0;
        if (ack_take) ack_clr[id_q] = 1'b1;

        // A fresh edge wins over a simultaneous software or ack clear.
        pending_d = (pending_q & ~w1c & ~ack_clr) | rise;

        // Withdrawal looks at the values that take effect on this edge.
        withdraw = !pending_d[id_q] || !enable_d[id_q] || !gie_d;

        cause            = '0;
        cause[DW-1]      = (state_q == ST_SERVICE);
        cause[ID_W-1:0]  = id_q;

        rd_d = '0;
        case (bus.addr)
            2'd0:    rd_d[N-1:0] = enable_q;
            2'd1:    rd_d[N-1:0] = pending_q;
            2'd2:    rd_d        = cause;
            default: rd_d[0]     = gie_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= '0;
            enable_q  <= '0;
            pending_q <= '0;
            gie_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            src_q     <= bus.irq_src;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            gie_q     <= gie_d;
            rd_q      <= rd_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gie_q && (|active)) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        id_q    <= sel_id;
                    end
                end
                ST_REQ: begin
                    if (ack_take) begin
                        state_q <= ST_SERVICE;
                        req_q   <= 1'b0;
                    end else if (withdraw) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (bus.irq_eoi) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data  = rd_q;
    assign bus.irq_req  = req_q;
    assign bus.irq_id   = id_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: drivers push expected outputs tagged with
// the clock count at which they must appear; a monitor pops and compares them.
module tb_irq_controller;
    localparam int K_RD    = 0;
    localparam int K_REQ   = 1;
    localparam int K_ID    = 2;
    localparam int K_STATE = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         cyc;
    int         total;
    int         bad;
    exp_t       exp_q[$];

    irq_controller_if #(.NUM_IRQ_SOURCES(4), .DATA_WIDTH(8)) bus ();

    irq_controller #(.NUM_IRQ_SOURCES(4), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic string kind_name(int k);
        case (k)
            K_RD:    return "rd_data";
            K_REQ:   return "irq_req";
            K_ID:    return "irq_id";
            default: return "state";
        endcase
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s @cyc %0d: got %02h required %02h", name, cyc, act, req);
        end
    endtask

    function automatic logic [7:0] sample(int k);
        case (k)
            K_RD:    return bus.rd_data;
            K_REQ:   return {7'd0, bus.irq_req};
            K_ID:    return {6'd0, bus.irq_id};
            default: return {6'd0, dbg_state};
        endcase
    endfunction

    // monitor: compares every expectation tagged for the edge just taken
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc = cyc + 1;
            for (int i = 0; i < exp_q.size();) begin
                if (exp_q[i].cyc == cyc) begin
                    check(kind_name(exp_q[i].kind), sample(exp_q[i].kind), exp_q[i].val);
                    exp_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    // driver tasks
    task automatic push_exp(int d, int k, logic [7:0] v);
        exp_t e;
        e.cyc  = cyc + d;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(logic [1:0] a, logic [7:0] d);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        step();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        cyc = 0;
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.irq_src = '0;
        bus.addr    = 2'd0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b0;

        // reset values
        push_exp(1, K_RD, 8'h00);
        push_exp(1, K_REQ, 8'h00);
        push_exp(1, K_ID, 8'h00);
        push_exp(1, K_STATE, 8'h00);
        step();
        rst = 1'b0;

        // basic request/ack/eoi on source 0
        wr(2'd0, 8'h01);
        wr(2'd3, 8'h01);
        bus.addr = 2'd1;
        bus.irq_src = 4'b0001;
        push_exp(1, K_REQ, 8'h00);
        push_exp(2, K_RD, 8'h01);
        push_exp(2, K_REQ, 8'h01);
        push_exp(2, K_ID, 8'h00);
        step();
        bus.irq_src = 4'b0000;
        step();
        bus.addr = 2'd2;
        bus.irq_ack = 1'b1;
        push_exp(1, K_REQ, 8'h00);
        push_exp(1, K_STATE, 8'h02);
        push_exp(2, K_RD, 8'h80);
        step();
        bus.irq_ack = 1'b0;
        step();
        bus.irq_eoi = 1'b1;
        push_exp(1, K_STATE, 8'h00);
        push_exp(1, K_RD, 8'h80);
        push_exp(2, K_RD, 8'h00);
        step();
        bus.irq_eoi = 1'b0;
        step();

        // simultaneous sources 3 and 1: lowest index first
        wr(2'd0, 8'h0F);
        bus.irq_src = 4'b1010;
        push_exp(2, K_REQ, 8'h01);
        push_exp(2, K_ID, 8'h01);
        step();
        bus.irq_src = 4'b0000;
        step();
        bus.irq_ack = 1'b1;
        push_exp(1, K_REQ, 8'h00);
        push_exp(1, K_STATE, 8'h02);
        step();
        bus.irq_ack = 1'b0;
        bus.addr = 2'd1;
        push_exp(1, K_RD, 8'h08);
        step();
        bus.irq_eoi = 1'b1;
        push_exp(1, K_STATE, 8'h00);
        push_exp(1, K_REQ, 8'h00);
        step();
        bus.irq_eoi = 1'b0;
        push_exp(1, K_REQ, 8'h01);
        push_exp(1, K_ID, 8'h03);
        step();
        bus.irq_ack = 1'b1;
        push_exp(1, K_STATE, 8'h02);
        push_exp(2, K_RD, 8'h00);
        step();
        bus.irq_ack = 1'b0;
        step();
        bus.irq_eoi = 1'b1;
        push_exp(1, K_STATE, 8'h00);
        step();
        bus.irq_eoi = 1'b0;

        // withdrawal by W1C, then W1C coinciding with ack
        bus.irq_src = 4'b0100;
        push_exp(2, K_REQ, 8'h01);
        push_exp(2, K_ID, 8'h02);
        step();
        bus.irq_src = 4'b0000;
        step();
        push_exp(1, K_RD, 8'h04);
        push_exp(1, K_REQ, 8'h00);
        push_exp(1, K_STATE, 8'h00);
        wr(2'd1, 8'h04);
        push_exp(1, K_RD, 8'h00);
        push_exp(1, K_REQ, 8'h00);
        step();
        bus.irq_src = 4'b0100;
        push_exp(2, K_REQ, 8'h01);
        push_exp(2, K_ID, 8'h02);
        step();
        bus.irq_src = 4'b0000;
        step();
        bus.irq_ack = 1'b1;
        push_exp(1, K_STATE, 8'h02);
        push_exp(1, K_REQ, 8'h00);
        wr(2'd1, 8'h04);
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b1;
        push_exp(1, K_STATE, 8'h00);
        step();
        bus.irq_eoi = 1'b0;

        // GIE off: pending accumulates, request only once GIE is set
        wr(2'd3, 8'h00);
        bus.addr = 2'd1;
        bus.irq_src = 4'b0101;
        push_exp(2, K_RD, 8'h05);
        push_exp(2, K_REQ, 8'h00);
        push_exp(3, K_REQ, 8'h00);
        step();
        bus.irq_src = 4'b0000;
        step();
        step();
        push_exp(1, K_REQ, 8'h00);
        push_exp(2, K_REQ, 8'h01);
        push_exp(2, K_ID, 8'h00);
        wr(2'd3, 8'h01);
        step();
        bus.irq_ack = 1'b1;
        push_exp(1, K_STATE, 8'h02);
        step();
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b1;
        push_exp(1, K_STATE, 8'h00);
        step();
        bus.irq_eoi = 1'b0;
        push_exp(1, K_REQ, 8'h01);
        push_exp(1, K_ID, 8'h02);
        step();
        bus.irq_ack = 1'b1;
        push_exp(1, K_STATE, 8'h02);
        step();
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b1;
        push_exp(1, K_STATE, 8'h00);
        step();
        bus.irq_eoi = 1'b0;

        // level held 10 cycles sets pending only once
        wr(2'd3, 8'h00);
        bus.addr = 2'd1;
        bus.irq_src = 4'b0010;
        push_exp(2, K_RD, 8'h02);
        repeat (4) step();
        push_exp(1, K_RD, 8'h02);
        wr(2'd1, 8'h02);
        bus.addr = 2'd1;
        push_exp(1, K_RD, 8'h00);
        push_exp(3, K_RD, 8'h00);
        repeat (5) step();
        bus.irq_src = 4'b0000;
        step();

        // stray ack in IDLE and stray eoi in REQ
        bus.irq_ack = 1'b1;
        push_exp(1, K_STATE, 8'h00);
        push_exp(1, K_REQ, 8'h00);
        step();
        bus.irq_ack = 1'b0;
        wr(2'd3, 8'h01);
        bus.irq_src = 4'b0010;
        push_exp(2, K_REQ, 8'h01);
        push_exp(2, K_ID, 8'h01);
        push_exp(2, K_STATE, 8'h01);
        step();
        bus.irq_src = 4'b0000;
        step();
        bus.irq_eoi = 1'b1;
        push_exp(1, K_STATE, 8'h01);
        push_exp(1, K_REQ, 8'h01);
        step();
        bus.irq_eoi = 1'b0;
        bus.irq_ack = 1'b1;
        push_exp(1, K_STATE, 8'h02);
        step();
        bus.irq_ack = 1'b0;
        bus.addr = 2'd2;
        push_exp(1, K_RD, 8'h81);
        step();

        // asynchronous reset during SERVICE, source high across release
        rst = 1'b1;
        bus.irq_src = 4'b0001;
        #1;
        check("rst_irq_req", {7'd0, bus.irq_req}, 8'h00);
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_state", {6'd0, dbg_state}, 8'h00);
        check("rst_irq_id", {6'd0, bus.irq_id}, 8'h00);
        step();
        rst = 1'b0;
        bus.addr = 2'd1;
        push_exp(1, K_RD, 8'h00);
        push_exp(2, K_RD, 8'h01);
        push_exp(2, K_REQ, 8'h00);
        step();
        step();
        bus.addr = 2'd0;
        push_exp(1, K_RD, 8'h00);
        step();
        bus.addr = 2'd3;
        push_exp(1, K_RD, 8'h00);
        step();
        bus.addr = 2'd2;
        push_exp(1, K_RD, 8'h00);
        step();
        bus.irq_src = 4'b0000;
        repeat (3) step();

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total = total + 1;
            bad = bad + 1;
            $display("FAIL unchecked_%s: got none required %02h at cyc %0d",
                     kind_name(e.kind), e.val, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller directly downstream of the memory-mapped timer/counter I/O device.
- Consumes the per-timer "interrupt occurred" flags, latches them as pending, masks them and prioritises them.
- Presents one request with its source ID to the RV32I core and runs a request/ack/end-of-interrupt handshake.
- Software sees it as a 4-register memory-mapped I/O device using the same addr/wr_data/rd_data style as the other I/O devices.

Parameters:
- NUM_IRQ_SOURCES, 4, number of interrupt inputs (one per timer set); must be ≤ DATA_WIDTH-1.
- DATA_WIDTH, 8, register and data-bus width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_src  input  NUM_IRQ_SOURCES  level interrupt flags from the timer counters; bit i corresponds to timer set i.
- addr  input  2  register select: 0=ENABLE, 1=PENDING, 2=CAUSE, 3=CTRL.
- wr_en  input  1  write strobe for the register selected by addr.
- wr_data  input  DATA_WIDTH  write data.
- rd_data  output  DATA_WIDTH  registered read data of the register selected by addr.
- irq_ack  input  1  core accepts the current request (one-cycle pulse).
- irq_eoi  input  1  core finished the handler (one-cycle pulse).
- irq_req  output  1  interrupt request to the core (registered).
- irq_id  output  $clog2(NUM_IRQ_SOURCES)  source index of the current request or in-service interrupt (registered).

Behaviour:
- Reset (async, rst=1):
  - ENABLE, PENDING, CTRL and the edge-detect register src_q are 0.
  - State is IDLE.
  - irq_req=0, irq_id=0, rd_data=0.
- Edge detect:
  - src_q <= irq_src every cycle.
  - pending[i] is set when irq_src[i]=1 and src_q[i]=0.
  - A source already high when reset is released produces a pending bit on the first clock after release.
- Registers (upper unused bits read 0 and ignore writes):
  - ENABLE: read/write mask.
  - PENDING: read; write-1-to-clear. A set and a clear of the same bit in the same cycle leave the bit set.
  - CAUSE: read-only. Bit DATA_WIDTH-1 is the in-service flag (state SERVICE). Low bits are irq_id.
  - CTRL: bit0 is global enable (GIE, read/write). Other bits are 0.
- Read: rd_data <= register[addr] on each clock, so data appears one cycle after addr. A read of PENDING in the same cycle as a write returns the pre-write value.
- Priority: lowest index wins. active = pending & ENABLE.
- State machine:
  - IDLE: if GIE and active≠0, go to REQ next edge, latch irq_id = lowest set index of active, and set irq_req=1.
  - REQ: irq_req=1 and irq_id held stable; a higher-priority arrival does not change irq_id.
    - On irq_ack: clear pending[irq_id], irq_req<=0, go to SERVICE.
    - Withdrawal: if pending[irq_id] or ENABLE[irq_id] becomes 0 (software), or GIE becomes 0, before ack, then irq_req<=0 and go to IDLE. If withdrawal and ack coincide, ack wins.
  - SERVICE: irq_req=0 and irq_id held. New edges keep accumulating in PENDING. On irq_eoi, go to IDLE.
    - The next request can assert at the earliest 2 edges after eoi: IDLE evaluates on the edge after the return.
- Ignored pulses: irq_ack outside REQ and irq_eoi outside SERVICE have no effect.
- Latency: source edge at cycle n → pending visible at n+1 → irq_req=1 at n+2 (from IDLE, with GIE=1 and enabled).
- Reset mid-operation: returns immediately to the reset values. Any in-flight request or service is lost.

Test Plan:
- Reset, ENABLE=0x01, CTRL=0x01, pulse irq_src[0] → PENDING=0x01 one cycle after the edge, irq_req=1 and irq_id=0 the following cycle; irq_ack → irq_req=0, CAUSE=0x80; irq_eoi → CAUSE=0x00.
- ENABLE=0x0F, GIE=1, raise irq_src[3] and irq_src[1] in the same cycle → irq_id=1; after ack/eoi → second request with irq_id=3, PENDING=0x00 after second ack.
- In REQ with irq_id=2, write PENDING=0x04 (W1C) → irq_req drops next edge, state IDLE, no ack needed; same write in the cycle of irq_ack → ack honoured, state SERVICE.
- GIE=0, pulse sources 0 and 2 → PENDING=0x05, irq_req stays 0; set GIE=1 → irq_req=1 with irq_id=0 two cycles after the write.
- Hold irq_src[1] high for 10 cycles → exactly one pending set; irq_ack in IDLE and irq_eoi in REQ ignored (state unchanged).
- Assert rst during SERVICE → irq_req=0, rd_data=0, all registers 0 immediately (asynchronous); source high at release → PENDING bit set on first clock.
